// File: rtl/dsec_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// dsec_ctrl_fsm
//
// Top-level control for the DSEC (compression / shift-concatenation /
// encryption) datapath. A registered state machine sits between the external
// bus handshake and the datapath modules. It provides:
//   - input handshake (rdy / valid_to_comp) towards the compression module
//   - an end-of-stream drain that asserts dump_comp until the compressor is
//     empty
//   - out_valid that is held until the receiver acknowledges with out_rcvd
//   - a sticky error flag with a coded cause (lowest code wins)
//   - an acknowledge timeout on out_valid
//
// Ports
//   clk            clock
//   rst            asynchronous, active-low reset
//   key_config     encryption keys are being configured
//   in_valid       bus input word present
//   in_last        with in_valid: final word of the stream
//   out_rcvd       receiver has taken the current output word
//   comp_rdy       compression module can accept input
//   scon_done      1-cycle pulse: shift-concatenation has a 64-bit word ready
//   valid_bits     valid bits still held in the compression module
//   err_clr        1-cycle pulse: clear the sticky error and leave ERR
//   rdy            DSEC can accept input (combinational)
//   valid_to_comp  input to compression is valid (combinational)
//   dump_comp      compressor must flush its partial word (combinational)
//   stall          all datapath modules hold state (combinational)
//   out_valid      output word valid (registered)
//   error          sticky error flag (registered)
//   error_code     cause of the latest error, codes 1..4 in bits [3:0]
//
// TO_W must be wide enough that 2**TO_W > TO_CYC. TO_CYC = 0 disables the
// acknowledge timeout.
// -----------------------------------------------------------------------------
module dsec_ctrl_fsm #(
    parameter int VB_W   = 7,
    parameter int ERR_W  = 64,
    parameter int TO_CYC = 1024,
    parameter int TO_W   = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_config,
    input  logic             in_valid,
    input  logic             in_last,
    input  logic             out_rcvd,
    input  logic             comp_rdy,
    input  logic             scon_done,
    input  logic [VB_W-1:0]  valid_bits,
    input  logic             err_clr,
    output logic             rdy,
    output logic             valid_to_comp,
    output logic             dump_comp,
    output logic             stall,
    output logic             out_valid,
    output logic             error,
    output logic [ERR_W-1:0] error_code
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_KEYCFG,
        S_RUN,
        S_DRAIN,
        S_ERR
    } state_t;

    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TO_CYC);
    localparam logic            TO_EN  = (TO_CYC != 0);

    state_t          state_q, state_d;
    logic            out_valid_q, out_valid_d;
    logic            error_q, error_d;
    logic [3:0]      code_q, code_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;

    logic            rdy_int;
    logic            accept;
    logic            err_ovf, err_ovr, err_key, err_to;
    logic [3:0]      new_code;

    // ------------------------------------------------------------------
    // Combinational handshake outputs
    // ------------------------------------------------------------------
    // A new scon word arriving while the previous one is still unacknowledged
    // blocks input so the compressor does not push more data behind it.
    assign rdy_int       = comp_rdy
                         & ((state_q == S_RUN) | (state_q == S_IDLE))
                         & ~(out_valid_q & scon_done);
    assign accept        = in_valid & rdy_int;

    assign rdy           = rdy_int;
    assign valid_to_comp = accept;
    assign dump_comp     = (state_q == S_DRAIN) && (valid_bits != '0);
    assign stall         = (state_q == S_KEYCFG) | (state_q == S_ERR);

    assign out_valid     = out_valid_q;
    assign error         = error_q;
    assign error_code    = ERR_W'(code_q);

    // ------------------------------------------------------------------
    // Error sources
    // ------------------------------------------------------------------
    assign err_ovf = in_valid & ~rdy_int & ~key_config & (state_q != S_ERR);
    assign err_ovr = scon_done & out_valid_q & ~out_rcvd;
    assign err_key = key_config & (state_q == S_DRAIN);
    assign err_to  = TO_EN & (to_cnt_q == TO_MAX);

    // Lowest code wins. Key configuration masks error detection entirely,
    // since the datapath is stalled and the bus is expected to be quiet.
    always_comb begin
        new_code = 4'd0;
        if (state_q != S_KEYCFG) begin
            if (err_ovf) begin
                new_code = 4'd1;
            end else if (err_ovr) begin
                new_code = 4'd2;
            end else if (err_key) begin
                new_code = 4'd3;
            end else if (err_to) begin
                new_code = 4'd4;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        error_d     = error_q;
        code_d      = code_q;
        out_valid_d = out_valid_q;
        to_cnt_d    = to_cnt_q;

        // Normal flow, ignoring errors.
        case (state_q)
            S_IDLE: begin
                if (key_config) begin
                    state_d = S_KEYCFG;
                end else if (in_valid) begin
                    state_d = S_RUN;
                end
            end
            S_KEYCFG: begin
                if (!key_config) begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (key_config) begin
                    state_d = S_KEYCFG;
                end else if (accept && in_last) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Leave only once the compressor is empty and the last output
                // word has been acknowledged.
                if ((valid_bits == '0) && !out_valid_q) begin
                    state_d = S_IDLE;
                end
            end
            S_ERR: begin
                state_d = S_ERR;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // err_clr outranks any error detected in the same cycle.
        if (err_clr) begin
            error_d = 1'b0;
            code_d  = 4'd0;
            if (state_q == S_ERR) begin
                state_d = S_IDLE;
            end
        end else if (new_code != 4'd0) begin
            error_d = 1'b1;
            code_d  = new_code;
            state_d = S_ERR;
        end

        // A fresh word takes precedence over an acknowledge of the old one,
        // so scon_done together with out_rcvd keeps out_valid high.
        if (state_d == S_KEYCFG) begin
            out_valid_d = 1'b0;
        end else if (scon_done) begin
            out_valid_d = 1'b1;
        end else if (out_rcvd) begin
            out_valid_d = 1'b0;
        end

        // Acknowledge timeout: counts unacknowledged out_valid cycles and
        // saturates, so the timeout error keeps firing until acknowledged.
        if (TO_EN && out_valid_q && !out_rcvd) begin
            if (to_cnt_q != TO_MAX) begin
                to_cnt_d = to_cnt_q + TO_W'(1);
            end
        end else begin
            to_cnt_d = '0;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            error_q     <= 1'b0;
            code_q      <= 4'd0;
            to_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            error_q     <= error_d;
            code_q      <= code_d;
            to_cnt_q    <= to_cnt_d;
        end
    end

endmodule

// File: tb/tb_dsec_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// tb_dsec_ctrl_fsm
//
// Bench for dsec_ctrl_fsm. Two instances share the same stimulus: dut_a with
// a 16-cycle acknowledge timeout and dut_b with the timeout disabled. A
// behavioural model of the control rules predicts every output each cycle;
// directed sequences add explicit expected values for the key scenarios,
// followed by a randomized run with occasional mid-stream resets.
// -----------------------------------------------------------------------------
module tb_dsec_ctrl_fsm;

    localparam int LIM_A = 16;
    localparam int LIM_B = 0;

    // model state names
    localparam int M_IDLE  = 0;
    localparam int M_KEY   = 1;
    localparam int M_RUN   = 2;
    localparam int M_DRAIN = 3;
    localparam int M_ERR   = 4;

    typedef struct {
        int st;
        bit ov;
        bit err;
        int code;
        int wait_n;   // consecutive unacknowledged out_valid cycles
    } mdl_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        key_config, in_valid, in_last, out_rcvd, comp_rdy, scon_done, err_clr;
    logic [6:0]  valid_bits;

    logic        rdy_a, vtc_a, dump_a, stall_a, ov_a, err_a;
    logic [63:0] code_a;
    logic        rdy_b, vtc_b, dump_b, stall_b, ov_b, err_b;
    logic [63:0] code_b;

    mdl_t ma, mb;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    dsec_ctrl_fsm #(.VB_W(7), .ERR_W(64), .TO_CYC(LIM_A), .TO_W(5)) dut_a (
        .clk(clk), .rst(rst), .key_config(key_config), .in_valid(in_valid),
        .in_last(in_last), .out_rcvd(out_rcvd), .comp_rdy(comp_rdy),
        .scon_done(scon_done), .valid_bits(valid_bits), .err_clr(err_clr),
        .rdy(rdy_a), .valid_to_comp(vtc_a), .dump_comp(dump_a), .stall(stall_a),
        .out_valid(ov_a), .error(err_a), .error_code(code_a)
    );

    dsec_ctrl_fsm #(.VB_W(7), .ERR_W(64), .TO_CYC(LIM_B), .TO_W(11)) dut_b (
        .clk(clk), .rst(rst), .key_config(key_config), .in_valid(in_valid),
        .in_last(in_last), .out_rcvd(out_rcvd), .comp_rdy(comp_rdy),
        .scon_done(scon_done), .valid_bits(valid_bits), .err_clr(err_clr),
        .rdy(rdy_b), .valid_to_comp(vtc_b), .dump_comp(dump_b), .stall(stall_b),
        .out_valid(ov_b), .error(err_b), .error_code(code_b)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    function automatic bit m_rdy(input mdl_t m);
        return comp_rdy && (m.st == M_RUN || m.st == M_IDLE) && !(m.ov && scon_done);
    endfunction

    function automatic mdl_t m_next(input mdl_t m, input int limit);
        mdl_t n;
        bit   r;
        bit   hit [1:4];
        int   code;
        n = m;
        r = m_rdy(m);
        hit[1] = in_valid && !r && !key_config && m.st != M_ERR;
        hit[2] = scon_done && m.ov && !out_rcvd;
        hit[3] = key_config && m.st == M_DRAIN;
        hit[4] = limit != 0 && m.wait_n >= limit;
        code = 0;
        if (m.st != M_KEY) begin
            for (int c = 4; c >= 1; c--) begin
                if (hit[c]) code = c;
            end
        end

        if (m.st == M_IDLE) begin
            if (key_config) n.st = M_KEY;
            else if (in_valid) n.st = M_RUN;
        end else if (m.st == M_KEY) begin
            if (!key_config) n.st = M_IDLE;
        end else if (m.st == M_RUN) begin
            if (key_config) n.st = M_KEY;
            else if (in_valid && r && in_last) n.st = M_DRAIN;
        end else if (m.st == M_DRAIN) begin
            if (valid_bits == 0 && !m.ov) n.st = M_IDLE;
        end

        if (err_clr) begin
            n.err  = 0;
            n.code = 0;
            if (m.st == M_ERR) n.st = M_IDLE;
        end else if (code != 0) begin
            n.err  = 1;
            n.code = code;
            n.st   = M_ERR;
        end

        if (n.st == M_KEY) n.ov = 0;
        else if (scon_done) n.ov = 1;
        else if (out_rcvd) n.ov = 0;

        if (limit != 0 && m.ov && !out_rcvd) n.wait_n = (m.wait_n + 1 > limit) ? limit : m.wait_n + 1;
        else n.wait_n = 0;
        return n;
    endfunction

    task automatic cmp_dut(input string p, input mdl_t m,
                           input logic r, input logic v, input logic d, input logic s,
                           input logic o, input logic e, input logic [63:0] c);
        bit mr;
        mr = m_rdy(m);
        chk({p, "_rdy"},   64'(r), 64'(mr));
        chk({p, "_vtc"},   64'(v), 64'(mr && in_valid));
        chk({p, "_dump"},  64'(d), 64'(m.st == M_DRAIN && valid_bits != 0));
        chk({p, "_stall"}, 64'(s), 64'(m.st == M_KEY || m.st == M_ERR));
        chk({p, "_ov"},    64'(o), 64'(m.ov));
        chk({p, "_err"},   64'(e), 64'(m.err));
        chk({p, "_code"},  c,      64'(m.code));
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic tick();
        #1;
        cmp_dut("a", ma, rdy_a, vtc_a, dump_a, stall_a, ov_a, err_a, code_a);
        cmp_dut("b", mb, rdy_b, vtc_b, dump_b, stall_b, ov_b, err_b, code_b);
        @(posedge clk);
        ma = m_next(ma, LIM_A);
        mb = m_next(mb, LIM_B);
        cyc++;
        @(negedge clk);
    endtask

    task automatic set_in(input logic kc, input logic iv, input logic il, input logic orc,
                          input logic cr, input logic sd, input logic ec, input logic [6:0] vb);
        key_config = kc; in_valid = iv; in_last = il; out_rcvd = orc;
        comp_rdy = cr; scon_done = sd; err_clr = ec; valid_bits = vb;
    endtask

    // Asynchronous reset applied mid-cycle; everything must drop at once.
    task automatic do_reset();
        set_in(0, 0, 0, 0, 0, 0, 0, 7'd0);
        #2;
        rst = 1'b0;
        #1;
        chk("rst_rdy",   64'(rdy_a),   64'd0);
        chk("rst_vtc",   64'(vtc_a),   64'd0);
        chk("rst_dump",  64'(dump_a),  64'd0);
        chk("rst_stall", 64'(stall_a), 64'd0);
        chk("rst_ov",    64'(ov_a),    64'd0);
        chk("rst_err",   64'(err_a),   64'd0);
        chk("rst_code",  code_a,       64'd0);
        chk("rst_ov_b",  64'(ov_b),    64'd0);
        chk("rst_err_b", 64'(err_b),   64'd0);
        ma = '{st: M_IDLE, ov: 0, err: 0, code: 0, wait_n: 0};
        mb = ma;
        @(negedge clk);
        rst = 1'b1;
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int n;
        rst = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 7'd0);
        @(negedge clk);
        do_reset();

        // Key configuration: out_valid pending beforehand is dropped.
        set_in(0, 0, 0, 0, 1, 1, 0, 7'd0);
        tick();
        set_in(1, 0, 0, 0, 1, 0, 0, 7'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("kc_stall", 64'(stall_a), 64'd1);
            chk("kc_rdy",   64'(rdy_a),   64'd0);
            chk("kc_ov",    64'(ov_a),    64'd0);
        end
        key_config = 1'b0;
        tick();
        #1;
        chk("kc_exit_stall", 64'(stall_a), 64'd0);
        chk("kc_exit_rdy",   64'(rdy_a),   64'd1);

        // Output word: out_valid for four cycles, acknowledged in the fourth.
        set_in(0, 1, 0, 0, 1, 0, 0, 7'd0);
        tick();
        set_in(0, 0, 0, 0, 1, 1, 0, 7'd0);
        tick();
        scon_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("ow_ov_hi", 64'(ov_a), 64'd1);
            if (i == 3) out_rcvd = 1'b1;
            tick();
        end
        chk("ow_ov_lo", 64'(ov_a),  64'd0);
        chk("ow_err",   64'(err_a), 64'd0);
        out_rcvd = 1'b0;

        // Input overflow, then clear.
        set_in(0, 1, 0, 0, 0, 0, 0, 7'd0);
        tick();
        chk("ovf_err",   64'(err_a),   64'd1);
        chk("ovf_code",  code_a,       64'd1);
        chk("ovf_stall", 64'(stall_a), 64'd1);
        set_in(0, 0, 0, 0, 0, 0, 1, 7'd0);
        tick();
        chk("clr_err",   64'(err_a),   64'd0);
        chk("clr_code",  code_a,       64'd0);
        chk("clr_stall", 64'(stall_a), 64'd0);
        set_in(0, 0, 0, 0, 1, 0, 0, 7'd0);
        #1;
        chk("clr_idle_rdy", 64'(rdy_a), 64'd1);

        // Output overrun, then overrun together with overflow.
        set_in(0, 0, 0, 0, 1, 1, 0, 7'd0);
        tick();
        tick();
        chk("ovr_code", code_a, 64'd2);
        set_in(0, 0, 0, 0, 1, 0, 1, 7'd0);
        tick();
        chk("ovr_clr_ov", 64'(ov_a), 64'd1);
        set_in(0, 1, 0, 0, 1, 1, 0, 7'd0);
        tick();
        chk("prio_code", code_a, 64'd1);
        set_in(0, 0, 0, 1, 1, 0, 1, 7'd0);
        tick();
        chk("prio_clr", 64'(err_a), 64'd0);

        // End-of-stream drain.
        set_in(0, 1, 0, 0, 1, 0, 0, 7'd0);
        tick();
        set_in(0, 1, 1, 0, 1, 0, 0, 7'd37);
        tick();
        set_in(0, 0, 0, 0, 1, 0, 0, 7'd37);
        #1;
        chk("dr_dump37", 64'(dump_a), 64'd1);
        tick();
        set_in(0, 0, 0, 0, 1, 1, 0, 7'd5);
        #1;
        chk("dr_dump5", 64'(dump_a), 64'd1);
        tick();
        set_in(0, 0, 0, 1, 1, 0, 0, 7'd0);
        #1;
        chk("dr_dump0", 64'(dump_a), 64'd0);
        chk("dr_ov",    64'(ov_a),   64'd1);
        tick();
        out_rcvd = 1'b0;
        #1;
        chk("dr_wait_rdy", 64'(rdy_a), 64'd0);
        tick();
        chk("dr_idle_rdy", 64'(rdy_a),  64'd1);
        chk("dr_idle_dump", 64'(dump_a), 64'd0);

        // Acknowledge timeout: dut_a errors 17 cycles after out_valid rises,
        // dut_b never does.
        do_reset();
        set_in(0, 0, 0, 0, 1, 1, 0, 7'd0);
        tick();
        scon_done = 1'b0;
        n = 0;
        while (n < 40 && code_a != 64'd4) begin
            tick();
            n++;
        end
        chk("to_cycles", 64'(n), 64'd17);
        for (int i = 0; i < 2000; i++) tick();
        chk("to0_err", 64'(err_b), 64'd0);
        chk("to0_ov",  64'(ov_b),  64'd1);
        chk("to16_code", code_a, 64'd4);

        // Randomized run with occasional mid-stream resets.
        do_reset();
        key_config = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
            end
            key_config = ($urandom_range(0, 24) == 0) ? 1'b1
                       : (key_config && $urandom_range(0, 2) != 0);
            in_valid   = ($urandom_range(0, 2) == 0);
            in_last    = ($urandom_range(0, 5) == 0);
            comp_rdy   = ($urandom_range(0, 7) != 0);
            scon_done  = ($urandom_range(0, 5) == 0);
            out_rcvd   = (i < 2000) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 19) == 0);
            err_clr    = ma.err ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 50) == 0);
            valid_bits = ($urandom_range(0, 2) == 0) ? 7'd0 : 7'($urandom_range(1, 127));
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
